// File: rtl/scan_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : scan_bist_ctrl
// Summary  : Scan-BIST controller for a single scan chain. An LFSR feeds
//            pseudo-random patterns serially into the chain, the block
//            sequences shift/capture, and the chain output is compacted
//            into a MISR signature.
// Revision : 1.0 - initial release
// ============================================================================
module scan_bist_ctrl #(
  parameter int                 CHAIN_LEN    = 16,
  parameter int                 NUM_PATTERNS = 64,
  parameter int                 LFSR_W       = 16,
  parameter logic [LFSR_W-1:0]  LFSR_TAPS    = 16'hB400,
  parameter logic [LFSR_W-1:0]  LFSR_SEED    = 16'hACE1,
  parameter int                 MISR_W       = 16,
  parameter logic [MISR_W-1:0]  MISR_TAPS    = 16'hB400
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              scan_out_i,
  output logic              scan_en_o,
  output logic              scan_in_o,
  output logic              capture_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [15:0]       pattern_cnt_o,
  output logic [MISR_W-1:0] signature_o
);

  // Shift counter is wide enough to hold CHAIN_LEN-1.
  localparam int CW = (CHAIN_LEN > 2) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [CW-1:0] C_LAST_SHIFT = CW'(CHAIN_LEN - 1);
  localparam logic [15:0]   C_NUM_PAT    = 16'(NUM_PATTERNS);
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [LFSR_W-1:0] C_SEED = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHIFT   = 3'd1,
    S_CAPTURE = 3'd2,
    S_UNLOAD  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [MISR_W-1:0]   misr_q, misr_d;
  logic [CW-1:0]       shift_cnt_q, shift_cnt_d;
  logic [15:0]         pcnt_q, pcnt_d;
  logic [LFSR_W-1:0]   lfsr_step;
  logic [MISR_W-1:0]   misr_step;
  logic [15:0]         pcnt_inc;

  // State and datapath registers; reset aborts any run and clears the signature.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      lfsr_q      <= C_SEED;
      misr_q      <= '0;
      shift_cnt_q <= '0;
      pcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      misr_q      <= misr_d;
      shift_cnt_q <= shift_cnt_d;
      pcnt_q      <= pcnt_d;
    end
  end

  // Next-state logic: sequencing, LFSR advance and MISR compaction.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    misr_d      = misr_q;
    shift_cnt_d = shift_cnt_q;
    pcnt_d      = pcnt_q;
    lfsr_step   = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    misr_step   = {misr_q[MISR_W-2:0], 1'b0}
                ^ (misr_q[MISR_W-1] ? MISR_TAPS : '0)
                ^ {{(MISR_W-1){1'b0}}, scan_out_i};
    pcnt_inc    = pcnt_q + 16'd1;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d     = S_SHIFT;
          lfsr_d      = C_SEED;
          misr_d      = '0;
          shift_cnt_d = '0;
          pcnt_d      = '0;
        end
      end
      S_SHIFT: begin
        lfsr_d = lfsr_step;
        // The first load only flushes pre-test contents; do not compact it.
        if (pcnt_q != 16'd0) misr_d = misr_step;
        if (shift_cnt_q == C_LAST_SHIFT) begin
          shift_cnt_d = '0;
          state_d     = S_CAPTURE;
        end else begin
          shift_cnt_d = shift_cnt_q + 1'b1;
        end
      end
      S_CAPTURE: begin
        pcnt_d  = pcnt_inc;
        state_d = (pcnt_inc == C_NUM_PAT) ? S_UNLOAD : S_SHIFT;
      end
      S_UNLOAD: begin
        misr_d = misr_step;
        if (shift_cnt_q == C_LAST_SHIFT) begin
          shift_cnt_d = '0;
          state_d     = S_DONE;
        end else begin
          shift_cnt_d = shift_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    scan_en_o = 1'b0;
    scan_in_o = 1'b0;
    capture_o = 1'b0;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    case (state_q)
      S_SHIFT: begin
        scan_en_o = 1'b1;
        scan_in_o = lfsr_q[LFSR_W-1];
        busy_o    = 1'b1;
      end
      S_CAPTURE: begin
        capture_o = 1'b1;
        busy_o    = 1'b1;
      end
      S_UNLOAD: begin
        scan_en_o = 1'b1;
        busy_o    = 1'b1;
      end
      S_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

  assign pattern_cnt_o = pcnt_q;
  assign signature_o   = misr_q;

endmodule
`default_nettype wire

// File: tb/tb_scan_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_scan_bist_ctrl
// Summary  : Directed self-checking bench for scan_bist_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scan_bist_ctrl;

  logic clk;
  logic rst, rst_b;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [15:0] lfsr_nx(input logic [15:0] l);
    return {l[14:0], ^(l & 16'hB400)};
  endfunction

  function automatic logic [15:0] misr_nx(input logic [15:0] m, input logic b);
    logic [15:0] r;
    r = {m[14:0], 1'b0};
    if (m[15]) r = r ^ 16'hB400;
    r[0] = r[0] ^ b;
    return r;
  endfunction

  // ---------------- DUT A: CHAIN_LEN=4, NUM_PATTERNS=2 ----------------
  logic start_a, so_a, en_a, si_a, cap_a, busy_a, done_a;
  logic [15:0] pcnt_a, sig_a;
  scan_bist_ctrl #(.CHAIN_LEN(4), .NUM_PATTERNS(2)) u_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .scan_out_i(so_a),
    .scan_en_o(en_a), .scan_in_o(si_a), .capture_o(cap_a), .busy_o(busy_a),
    .done_o(done_a), .pattern_cnt_o(pcnt_a), .signature_o(sig_a));

  // ---------------- DUT B: defaults; DUT Z: seed 0 ----------------
  logic start_b, so_b, en_b, si_b, cap_b, busy_b, done_b;
  logic [15:0] pcnt_b, sig_b;
  scan_bist_ctrl u_b (
    .clk_i(clk), .rst_i(rst_b), .start_i(start_b), .scan_out_i(so_b),
    .scan_en_o(en_b), .scan_in_o(si_b), .capture_o(cap_b), .busy_o(busy_b),
    .done_o(done_b), .pattern_cnt_o(pcnt_b), .signature_o(sig_b));

  logic en_z, si_z, cap_z, busy_z, done_z;
  logic [15:0] pcnt_z, sig_z;
  scan_bist_ctrl #(.NUM_PATTERNS(1), .LFSR_SEED(16'h0000)) u_z (
    .clk_i(clk), .rst_i(rst_b), .start_i(start_b), .scan_out_i(1'b0),
    .scan_en_o(en_z), .scan_in_o(si_z), .capture_o(cap_z), .busy_o(busy_z),
    .done_o(done_z), .pattern_cnt_o(pcnt_z), .signature_o(sig_z));

  // ---------------- DUT C: 4-cell chain model, D = ~Q ----------------
  logic start_c, en_c, si_c, cap_c, busy_c, done_c, so_c, stuck;
  logic [15:0] pcnt_c, sig_c;
  logic [3:0] chain;
  logic q2;
  initial chain = 4'b0110;
  assign q2   = stuck ? 1'b0 : chain[2];
  assign so_c = chain[3];
  always @(posedge clk) begin
    if (en_c)       chain <= {q2, chain[1], chain[0], si_c};
    else if (cap_c) chain <= ~{chain[3], q2, chain[1], chain[0]};
  end
  scan_bist_ctrl #(.CHAIN_LEN(4), .NUM_PATTERNS(3)) u_c (
    .clk_i(clk), .rst_i(rst), .start_i(start_c), .scan_out_i(so_c),
    .scan_en_o(en_c), .scan_in_o(si_c), .capture_o(cap_c), .busy_o(busy_c),
    .done_o(done_c), .pattern_cnt_o(pcnt_c), .signature_o(sig_c));

  // Golden signature of DUT C's run, optionally with cell 2 output stuck at 0.
  function automatic logic [15:0] gold_chain(input bit stk);
    logic [15:0] l, m;
    logic [3:0] ch;
    logic g2;
    l = 16'hACE1; m = '0; ch = '0;
    for (int p = 0; p < 3; p++) begin
      for (int s = 0; s < 4; s++) begin
        if (p > 0) m = misr_nx(m, ch[3]);
        g2 = stk ? 1'b0 : ch[2];
        ch = {g2, ch[1], ch[0], l[15]};
        l  = lfsr_nx(l);
      end
      g2 = stk ? 1'b0 : ch[2];
      ch = ~{ch[3], g2, ch[1], ch[0]};
    end
    for (int s = 0; s < 4; s++) begin
      m  = misr_nx(m, ch[3]);
      g2 = stk ? 1'b0 : ch[2];
      ch = {g2, ch[1], ch[0], 1'b0};
    end
    return m;
  endfunction

  // Per-cycle vectors for DUT A, cycle 1 = first SHIFT cycle.
  typedef struct {
    logic        start;
    logic        so;
    logic        en;
    logic        si;
    logic        cap;
    logic        busy;
    logic        done;
    logic [15:0] pcnt;
    logic [15:0] sig;
  } vec_t;
  vec_t tbl [16];

  task automatic run_table(input int run);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      start_a = tbl[i].start;
      so_a    = (run == 2 && i < 4) ? 1'b0 : tbl[i].so;
      @(negedge clk);
      check($sformatf("run%0d c%0d scan_en", run, i+1), {31'd0, en_a},   {31'd0, tbl[i].en});
      check($sformatf("run%0d c%0d scan_in", run, i+1), {31'd0, si_a},   {31'd0, tbl[i].si});
      check($sformatf("run%0d c%0d capture", run, i+1), {31'd0, cap_a},  {31'd0, tbl[i].cap});
      check($sformatf("run%0d c%0d busy", run, i+1),    {31'd0, busy_a}, {31'd0, tbl[i].busy});
      check($sformatf("run%0d c%0d done", run, i+1),    {31'd0, done_a}, {31'd0, tbl[i].done});
      check($sformatf("run%0d c%0d pcnt", run, i+1),    {16'd0, pcnt_a}, {16'd0, tbl[i].pcnt});
      check($sformatf("run%0d c%0d sig", run, i+1),     {16'd0, sig_a},  {16'd0, tbl[i].sig});
    end
  endtask

  task automatic start_c_run;
    @(negedge clk); start_c = 1'b1;
    @(posedge clk); #1; start_c = 1'b0;
  endtask

  task automatic wait_done_c(input string name);
    int n;
    n = 0;
    while (!done_c && n < 100) begin @(posedge clk); #1; n++; end
    check({name, " done reached"}, {31'd0, done_c}, 32'd1);
  endtask

  initial begin
    logic [15:0] g0, g1, lm, lz, exp_sig;
    int n;
    //            start so  en  si  cap busy done pcnt   sig
    tbl[0]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,16'd0,16'h0000};
    tbl[1]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,16'd0,16'h0000};
    tbl[2]  = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,16'd0,16'h0000};
    tbl[3]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,16'd0,16'h0000};
    tbl[4]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,16'd0,16'h0000};
    tbl[5]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,16'd1,16'h0000};
    tbl[6]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,16'd1,16'h0001};
    tbl[7]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,16'd1,16'h0002};
    tbl[8]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,16'd1,16'h0005};
    tbl[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,16'd1,16'h000B};
    tbl[10] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,16'd2,16'h000B};
    tbl[11] = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,16'd2,16'h0016};
    tbl[12] = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,16'd2,16'h002D};
    tbl[13] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,16'd2,16'h005B};
    tbl[14] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,16'd2,16'h00B6};
    tbl[15] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,16'd2,16'h00B6};

    rst = 1'b1; rst_b = 1'b1;
    start_a = 1'b0; so_a = 1'b0; start_b = 1'b0; so_b = 1'b1;
    start_c = 1'b0; stuck = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0; rst_b = 1'b0;
    @(negedge clk);

    // Reset state
    check("reset scan_en", {31'd0, en_a},   32'd0);
    check("reset scan_in", {31'd0, si_a},   32'd0);
    check("reset capture", {31'd0, cap_a},  32'd0);
    check("reset busy",    {31'd0, busy_a}, 32'd0);
    check("reset done",    {31'd0, done_a}, 32'd0);
    check("reset pcnt",    {16'd0, pcnt_a}, 32'd0);
    check("reset sig",     {16'd0, sig_a},  32'd0);

    // Timing table, started from IDLE, then restarted from DONE with the
    // first-pattern scan_out flipped to 0: identical outputs expected.
    start_a = 1'b1;
    run_table(1);
    start_a = 1'b1;
    run_table(2);

    // Real chain with D=~Q: fault-free vs cell-2 stuck-at-0.
    g0 = gold_chain(1'b0);
    g1 = gold_chain(1'b1);
    start_c_run();
    wait_done_c("chain good");
    check("chain good pcnt", {16'd0, pcnt_c}, 32'd3);
    check("chain good sig",  {16'd0, sig_c},  {16'd0, g0});
    stuck = 1'b1;
    start_c_run();
    wait_done_c("chain stuck");
    check("chain stuck sig", {16'd0, sig_c}, {16'd0, g1});
    n_total++;
    if (sig_c != g0) n_pass++;
    else $display("FAIL chain stuck sig differs: got %0h same as fault-free %0h", sig_c, g0);

    // Reset mid-SHIFT on default configuration.
    @(negedge clk); start_b = 1'b1;
    @(posedge clk); #1; start_b = 1'b0;
    repeat (19) @(posedge clk);
    #3;
    check("midrun pcnt", {16'd0, pcnt_b}, 32'd1);
    check("midrun sig",  {16'd0, sig_b},  32'h3);
    rst_b = 1'b1;
    #1;
    check("async rst scan_en", {31'd0, en_b},   32'd0);
    check("async rst busy",    {31'd0, busy_b}, 32'd0);
    check("async rst capture", {31'd0, cap_b},  32'd0);
    check("async rst done",    {31'd0, done_b}, 32'd0);
    check("async rst pcnt",    {16'd0, pcnt_b}, 32'd0);
    check("async rst sig",     {16'd0, sig_b},  32'd0);

    // Full default run after reset; seed-0 instance runs alongside.
    @(negedge clk); rst_b = 1'b0; start_b = 1'b1;
    @(posedge clk); #1; start_b = 1'b0;
    lm = 16'hACE1;
    lz = 16'h0001;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      check($sformatf("lfsr bit%0d", i),      {31'd0, si_b}, {31'd0, lm[15]});
      check($sformatf("seed0 lfsr bit%0d", i), {31'd0, si_z}, {31'd0, lz[15]});
      lm = lfsr_nx(lm);
      lz = lfsr_nx(lz);
    end
    n = 16;
    while (!done_b && n < 2000) begin @(posedge clk); #1; n++; end
    check("run length", n - 1, 32'd1104);
    check("default pcnt", {16'd0, pcnt_b}, 32'd64);
    exp_sig = '0;
    for (int i = 0; i < 63 * 16 + 16; i++) exp_sig = misr_nx(exp_sig, 1'b1);
    check("default sig", {16'd0, sig_b}, {16'd0, exp_sig});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
